// File: rtl/sram_responder.sv
// sram_responder: on-chip stand-in for the SLC3 board SRAM.
// Clears its storage after reset, then serves active-low controlled reads and
// byte-lane writes. Reads are delayed by READ_LAT cycles so the processor's
// memory state machine sees realistic wait states.
module sram_responder #(
    parameter int ADDR_W   = 10,
    parameter int READ_LAT = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [19:0] A,
    input  logic        CE,
    input  logic        OE,
    input  logic        WE,
    input  logic        UB,
    input  logic        LB,
    inout  wire  [15:0] Mem_Bus,
    output logic        Init_Done,
    output logic        Rd_Valid,
    output logic        Oor_Err
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
    localparam logic [2:0] LAT = 3'(READ_LAT);

    typedef enum logic [1:0] {INIT, IDLE, READ_WAIT, READ_DRIVE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [2:0]        cnt;
    logic [19:0]       a_lat;
    logic [15:0]       rdata;
    logic              last_vld;
    logic              last_wr;
    logic [19:0]       last_a;
    logic [15:0]       mem [DEPTH];

    logic              wr;
    logic              rd;
    logic              oor;
    logic              new_acc;
    logic              drive;
    logic [ADDR_W-1:0] idx;
    logic [15:0]       rd_word;

    // Bus decode: write wins over output enable; nothing decodes during INIT.
    always_comb begin
        wr      = (state != INIT) && !CE && !WE;
        rd      = (state != INIT) && !CE && WE && !OE;
        oor     = |A[19:ADDR_W];
        idx     = A[ADDR_W-1:0];
        new_acc = !(last_vld && (last_wr == wr) && (last_a == A));
        rd_word = oor ? 16'h0000 : mem[idx];
        drive   = (state == READ_DRIVE) && !CE && !OE && WE;
    end

    // The enable drops combinationally with CE/OE/WE so the bus never fights.
    assign Mem_Bus  = drive ? rdata : 16'hzzzz;
    assign Rd_Valid = drive;

    // Access FSM: init sweep, read wait states, read drive, out-of-range flag.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= INIT;
            ptr       <= '0;
            cnt       <= '0;
            a_lat     <= '0;
            rdata     <= '0;
            last_vld  <= 1'b0;
            last_wr   <= 1'b0;
            last_a    <= '0;
            Init_Done <= 1'b0;
            Oor_Err   <= 1'b0;
        end else begin
            Oor_Err <= 1'b0;
            if (state == INIT) begin
                ptr <= ptr + 1'b1;
                if (ptr == LAST_PTR) begin
                    state     <= IDLE;
                    Init_Done <= 1'b1;
                end
            end else begin
                last_vld <= wr || rd;
                last_wr  <= wr;
                last_a   <= A;
                if ((wr || rd) && oor && new_acc)
                    Oor_Err <= 1'b1;
                if (wr) begin
                    state <= IDLE;
                    cnt   <= '0;
                end else if (rd) begin
                    if (state == IDLE || A != a_lat) begin
                        // Read start (or restart on a new address).
                        a_lat <= A;
                        cnt   <= 3'd1;
                        if (LAT == 3'd1) begin
                            state <= READ_DRIVE;
                            rdata <= rd_word;
                        end else begin
                            state <= READ_WAIT;
                        end
                    end else if (state == READ_WAIT) begin
                        cnt <= cnt + 3'd1;
                        if (cnt + 3'd1 == LAT) begin
                            state <= READ_DRIVE;
                            rdata <= rd_word;
                        end
                    end
                end else begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            end
        end
    end

    // Storage: init sweep clears one word per cycle, writes honour byte lanes.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            if (state == INIT) begin
                mem[ptr] <= 16'h0000;
            end else if (wr && !oor) begin
                if (!UB) mem[idx][15:8] <= Mem_Bus[15:8];
                if (!LB) mem[idx][7:0]  <= Mem_Bus[7:0];
            end
        end
    end

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: init timing, reads, byte lanes,
// address restart, out-of-range handling, write-first and reset recovery.
module tb_sram_responder;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [19:0] A;
    logic        CE, OE, WE, UB, LB;
    wire  [15:0] Mem_Bus;
    logic        Init_Done, Rd_Valid, Oor_Err;
    logic [15:0] tb_drv;
    logic        tb_en;

    int pass_cnt  = 0;
    int check_cnt = 0;

    assign Mem_Bus = tb_en ? tb_drv : 16'hzzzz;

    sram_responder #(.ADDR_W(10), .READ_LAT(2)) dut (
        .Clk(Clk), .Reset(Reset), .A(A), .CE(CE), .OE(OE), .WE(WE),
        .UB(UB), .LB(LB), .Mem_Bus(Mem_Bus), .Init_Done(Init_Done),
        .Rd_Valid(Rd_Valid), .Oor_Err(Oor_Err)
    );

    always #5 Clk = ~Clk;

    task automatic bus_idle();
        CE = 1'b1; OE = 1'b1; WE = 1'b1; UB = 1'b1; LB = 1'b1;
        tb_en = 1'b0; tb_drv = 16'h0000; A = '0;
    endtask

    task automatic set_write(input logic [19:0] a, input logic [15:0] d,
                             input logic ub, input logic lb);
        A = a; CE = 1'b0; OE = 1'b1; WE = 1'b0; UB = ub; LB = lb;
        tb_drv = d; tb_en = 1'b1;
    endtask

    task automatic set_read(input logic [19:0] a);
        tb_en = 1'b0; A = a; CE = 1'b0; OE = 1'b0; WE = 1'b1; UB = 1'b0; LB = 1'b0;
    endtask

    // One-cycle write, leaves the bus idle at a negedge.
    task automatic do_write(input logic [19:0] a, input logic [15:0] d,
                            input logic ub, input logic lb);
        @(negedge Clk); set_write(a, d, ub, lb);
        @(negedge Clk); bus_idle();
    endtask

    // Starts a read and waits for Rd_Valid; read stays asserted afterwards.
    task automatic do_read(input logic [19:0] a, output logic [15:0] d, output int lat);
        @(negedge Clk); set_read(a);
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            lat++;
            if (Rd_Valid) break;
        end
        d = Mem_Bus;
    endtask

    // Counts cycles until Init_Done rises after Reset is released.
    task automatic wait_init(output int n);
        n = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge Clk);
            n++;
            if (Init_Done) break;
        end
    endtask

    task automatic test_reset();
        int n;
        logic [15:0] d;
        int lat;
        @(negedge Clk); bus_idle(); Reset = 1'b1;
        repeat (2) @(negedge Clk);
        check_cnt++;
        if (Init_Done !== 1'b0 || Rd_Valid !== 1'b0 || Oor_Err !== 1'b0)
            $display("FAIL reset_flags: done=%b valid=%b oor=%b, want 0/0/0", Init_Done, Rd_Valid, Oor_Err);
        else pass_cnt++;
        Reset = 1'b0;
        wait_init(n);
        check_cnt++;
        if (n !== 1024) $display("FAIL init_cycles: got %0d, want 1024", n);
        else pass_cnt++;
        do_read(20'h00003, d, lat);
        check_cnt++;
        if (lat !== 2 || d !== 16'h0000) $display("FAIL init_clear: lat=%0d data=%h, want 2/0000", lat, d);
        else pass_cnt++;
        bus_idle();
    endtask

    task automatic test_read_latency();
        logic [15:0] d;
        do_write(20'h00005, 16'h3333, 1'b0, 1'b0);
        @(negedge Clk); set_read(20'h00005);
        @(negedge Clk);
        check_cnt++;
        if (Rd_Valid !== 1'b0) $display("FAIL read_wait: valid=%b, want 0", Rd_Valid);
        else pass_cnt++;
        @(negedge Clk);
        d = Mem_Bus;
        check_cnt++;
        if (Rd_Valid !== 1'b1 || d !== 16'h3333) $display("FAIL read_drive: valid=%b data=%h, want 1/3333", Rd_Valid, d);
        else pass_cnt++;
        bus_idle();
    endtask

    task automatic test_byte_lanes();
        logic [15:0] d;
        int lat;
        do_write(20'h00007, 16'hABCD, 1'b0, 1'b0);
        do_write(20'h00007, 16'h1200, 1'b0, 1'b1);
        do_read(20'h00007, d, lat);
        check_cnt++;
        if (d !== 16'h12CD) $display("FAIL upper_lane: got %h, want 12CD", d);
        else pass_cnt++;
        bus_idle();
        do_write(20'h00007, 16'h0034, 1'b1, 1'b0);
        do_read(20'h00007, d, lat);
        check_cnt++;
        if (d !== 16'h1234) $display("FAIL lower_lane: got %h, want 1234", d);
        else pass_cnt++;
        bus_idle();
        do_write(20'h00007, 16'hFFFF, 1'b1, 1'b1);
        do_read(20'h00007, d, lat);
        check_cnt++;
        if (d !== 16'h1234) $display("FAIL no_lane: got %h, want 1234", d);
        else pass_cnt++;
        bus_idle();
    endtask

    task automatic test_addr_change();
        logic [15:0] d;
        int lat;
        do_write(20'h00006, 16'h6666, 1'b0, 1'b0);
        do_read(20'h00005, d, lat);
        check_cnt++;
        if (d !== 16'h3333 || lat !== 2) $display("FAIL read5: data=%h lat=%0d, want 3333/2", d, lat);
        else pass_cnt++;
        A = 20'h00006;
        @(negedge Clk);
        check_cnt++;
        if (Rd_Valid !== 1'b0) $display("FAIL addr_restart: valid=%b, want 0", Rd_Valid);
        else pass_cnt++;
        @(negedge Clk);
        d = Mem_Bus;
        check_cnt++;
        if (Rd_Valid !== 1'b1 || d !== 16'h6666) $display("FAIL read6: valid=%b data=%h, want 1/6666", Rd_Valid, d);
        else pass_cnt++;
        OE = 1'b1;
        #1;
        check_cnt++;
        if (Rd_Valid !== 1'b0) $display("FAIL oe_release: valid=%b, want 0", Rd_Valid);
        else pass_cnt++;
        bus_idle();
    endtask

    task automatic test_oor();
        logic [15:0] d;
        int lat;
        @(negedge Clk); set_write(20'h80005, 16'hBEEF, 1'b0, 1'b0);
        @(negedge Clk);
        check_cnt++;
        if (Oor_Err !== 1'b1) $display("FAIL oor_wr_pulse: got %b, want 1", Oor_Err);
        else pass_cnt++;
        @(negedge Clk);
        check_cnt++;
        if (Oor_Err !== 1'b0) $display("FAIL oor_wr_single: got %b, want 0", Oor_Err);
        else pass_cnt++;
        bus_idle();
        do_read(20'h00005, d, lat);
        check_cnt++;
        if (d !== 16'h3333) $display("FAIL oor_wr_dropped: got %h, want 3333", d);
        else pass_cnt++;
        bus_idle();
        @(negedge Clk); set_read(20'h80005);
        @(negedge Clk);
        check_cnt++;
        if (Oor_Err !== 1'b1 || Rd_Valid !== 1'b0) $display("FAIL oor_rd_start: oor=%b valid=%b, want 1/0", Oor_Err, Rd_Valid);
        else pass_cnt++;
        @(negedge Clk);
        d = Mem_Bus;
        check_cnt++;
        if (Oor_Err !== 1'b0 || Rd_Valid !== 1'b1 || d !== 16'h0000)
            $display("FAIL oor_rd_data: oor=%b valid=%b data=%h, want 0/1/0000", Oor_Err, Rd_Valid, d);
        else pass_cnt++;
        bus_idle();
    endtask

    task automatic test_back_to_back();
        logic [15:0] d;
        @(negedge Clk); set_write(20'h00009, 16'h5A5A, 1'b0, 1'b0);
        @(negedge Clk); set_read(20'h00009);
        repeat (2) @(negedge Clk);
        d = Mem_Bus;
        check_cnt++;
        if (Rd_Valid !== 1'b1 || d !== 16'h5A5A) $display("FAIL write_first: valid=%b data=%h, want 1/5A5A", Rd_Valid, d);
        else pass_cnt++;
        // Write during the drive phase aborts the read.
        set_write(20'h0000A, 16'hC3C3, 1'b0, 1'b0);
        @(negedge Clk);
        check_cnt++;
        if (Rd_Valid !== 1'b0) $display("FAIL write_abort: valid=%b, want 0", Rd_Valid);
        else pass_cnt++;
        set_read(20'h0000A);
        @(negedge Clk);
        check_cnt++;
        if (Rd_Valid !== 1'b0) $display("FAIL abort_restart: valid=%b, want 0", Rd_Valid);
        else pass_cnt++;
        @(negedge Clk);
        d = Mem_Bus;
        check_cnt++;
        if (Rd_Valid !== 1'b1 || d !== 16'hC3C3) $display("FAIL abort_read: valid=%b data=%h, want 1/C3C3", Rd_Valid, d);
        else pass_cnt++;
        bus_idle();
    endtask

    task automatic test_reset_recovery();
        logic [15:0] d;
        int lat;
        int n;
        do_read(20'h00005, d, lat);
        Reset = 1'b1;
        @(negedge Clk);
        check_cnt++;
        if (Rd_Valid !== 1'b0 || Init_Done !== 1'b0) $display("FAIL rst_in_read: valid=%b done=%b, want 0/0", Rd_Valid, Init_Done);
        else pass_cnt++;
        bus_idle();
        Reset = 1'b0;
        repeat (300) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        repeat (500) @(negedge Clk);
        // Accesses during INIT are ignored.
        set_write(20'h80002, 16'hFFFF, 1'b0, 1'b0);
        @(negedge Clk);
        check_cnt++;
        if (Oor_Err !== 1'b0 || Init_Done !== 1'b0) $display("FAIL init_oor: oor=%b done=%b, want 0/0", Oor_Err, Init_Done);
        else pass_cnt++;
        set_write(20'h00002, 16'hFFFF, 1'b0, 1'b0);
        @(negedge Clk);
        bus_idle();
        wait_init(n);
        check_cnt++;
        if (n !== 1024 - 502) $display("FAIL init_restart: got %0d more cycles, want %0d", n, 1024 - 502);
        else pass_cnt++;
        do_read(20'h00002, d, lat);
        check_cnt++;
        if (d !== 16'h0000) $display("FAIL init_write_ignored: got %h, want 0000", d);
        else pass_cnt++;
        bus_idle();
        do_read(20'h00005, d, lat);
        check_cnt++;
        if (d !== 16'h0000) $display("FAIL reset_cleared: got %h, want 0000", d);
        else pass_cnt++;
        bus_idle();
    endtask

    initial begin
        Reset = 1'b1;
        bus_idle();
        test_reset();
        test_read_latency();
        test_byte_lanes();
        test_addr_change();
        test_oor();
        test_back_to_back();
        test_reset_recovery();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Memory-side end of the SLC3 SRAM interface: it answers the processor's 20-bit address, active-low control and 16-bit bidirectional Mem_Bus from on-chip storage.
- It replaces the board SRAM in simulation and in the FPGA-only build.
- It clears its storage after reset.
- It models the access latency as read wait states, so the processor's memory state-machine timing is exercised.

Parameters:
- ADDR_W, 10, number of implemented word-address bits (DEPTH = 2**ADDR_W words of 16 bits).
- READ_LAT, 2, clock cycles from read start to valid data on Mem_Bus (1..7).

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- A  input  20  word address from processor.
- CE  input  1  chip enable, active low.
- OE  input  1  output enable, active low.
- WE  input  1  write enable, active low.
- UB  input  1  upper-byte lane enable (bits 15:8), active low.
- LB  input  1  lower-byte lane enable (bits 7:0), active low.
- Mem_Bus  inout  16  bidirectional data bus; driven by this block only during valid reads.
- Init_Done  output  1  high once post-reset clear is complete.
- Rd_Valid  output  1  high while this block drives valid read data.
- Oor_Err  output  1  one-cycle pulse when an access targets A[19:ADDR_W] != 0.

Behaviour:
- Reset (sampled on rising Clk with Reset=1), from any state, including mid-read or mid-init:
  - state goes to INIT; init pointer = 0; latency counter = 0.
  - Init_Done=0, Rd_Valid=0, Oor_Err=0; Mem_Bus = Z.
- INIT state:
  - Writes 16'h0000 to one word per cycle, pointer 0 to DEPTH-1.
  - After the write to DEPTH-1, goes to IDLE; Init_Done=1 from the next cycle.
  - Init takes exactly DEPTH cycles after Reset deasserts.
  - All bus accesses during INIT are ignored: no write, Mem_Bus=Z, no Oor_Err.
- Access decode (IDLE/READ states, registered on each rising Clk):
  - Write: CE=0 and WE=0. Write has priority over OE.
  - Read: CE=0, WE=1, OE=0.
  - Otherwise: idle.
- Write:
  - Commits at every rising edge where the write condition holds.
  - Lanes: UB=0 writes bits 15:8; LB=0 writes bits 7:0; UB=LB=1 writes nothing.
  - Mem_Bus is never driven by this block while WE=0.
  - A write aborts any read in progress; the FSM returns to IDLE.
- IDLE -> READ_WAIT on the first cycle the read condition holds:
  - Latch A; counter = 1.
  - Each cycle the read condition still holds and A equals the latched address, counter increments.
  - When counter reaches READ_LAT, go to READ_DRIVE.
  - Data appears on Mem_Bus READ_LAT cycles after the read-start edge.
- READ_DRIVE:
  - Registered data word (full 16 bits; UB/LB ignored on reads) is driven on Mem_Bus; Rd_Valid=1.
  - Stays while the read condition holds and A is unchanged.
- Address change during READ_WAIT or READ_DRIVE (read condition still true): restart at counter=1 with the new address; Rd_Valid=0; Mem_Bus=Z.
- Read condition drops (CE, OE or WE change): return to IDLE. Mem_Bus goes Z and Rd_Valid goes 0 combinationally in the same cycle; no bus contention allowed.
- Out-of-range (A[19:ADDR_W] != 0):
  - Write is dropped.
  - Read completes its latency and drives 16'h0000.
  - Oor_Err pulses for one cycle at access start; no pulse for repeated cycles of the same access.
- Read of a word written in the immediately preceding cycle returns the new value (write-first).
- Mem_Bus drive uses a single tri-state enable = (state==READ_DRIVE) & ~CE & ~OE & WE.

Test Plan:
- Reset=1 for 2 cycles, then 0 -> Init_Done=0 for exactly 1024 cycles, then 1. Read any address afterward -> 16'h0000.
- Write A=20'h00005, Mem_Bus=16'h3333, UB=LB=0. Then read A=20'h00005 -> Mem_Bus=Z for 1 cycle, 16'h3333 with Rd_Valid=1 from the 2nd cycle after read start.
- Byte lanes: write 16'hABCD to A=7 (both lanes), then 16'h1200 with UB=0, LB=1 -> read returns 16'h12CD. Then write 16'h0034 with UB=1, LB=0 -> read returns 16'h1234.
- Read A=5 in READ_DRIVE, then A changes to 6 -> Mem_Bus=Z and Rd_Valid=0 next cycle, word 6 valid 2 cycles later. Deassert OE -> Mem_Bus=Z in the same cycle.
- Access to A=20'h80005 -> Oor_Err single-cycle pulse, write dropped (word 5 unchanged), read returns 16'h0000.
- Assert Reset during READ_DRIVE and again mid-INIT (pointer≈300) -> Mem_Bus=Z next edge, Init_Done=0, init restarts from 0 and takes a full 1024 cycles.
